// File: rtl/telemeter_system_mult_sequencer.sv
// Multiply sequencer: drives an external 16x16 partial-product cell in one
// or two passes to form 32x32 low-word or high-word (signed/unsigned) results.
module telemeter_system_mult_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3
);

    typedef enum logic [2:0] {
        IDLE, ISSUE1, WAIT1, CAPT1,
        ISSUE2, WAIT2, CAPT2, RESP
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(MUL_LATENCY - 2);

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [49:0] acc_q, acc_sum;
    logic [31:0] result_q;
    logic [31:0] corr, hi;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_ready = 1'b0;
        mul_en    = 1'b0;
        mul_src1  = '0;
        mul_src2  = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ISSUE1;
            end
            ISSUE1: begin
                mul_en   = 1'b1;
                mul_src1 = a_q;
                mul_src2 = b_q;
                cnt_nx   = '0;
                state_nx = (MUL_LATENCY == 1) ? CAPT1 : WAIT1;
            end
            WAIT1: begin
                mul_en   = 1'b1;
                mul_src1 = a_q;
                mul_src2 = b_q;
                if (cnt == WAIT_LAST) state_nx = CAPT1;
                else cnt_nx = cnt + 2'd1;
            end
            CAPT1: begin
                state_nx = (op_q == 2'b00) ? RESP : ISSUE2;
            end
            ISSUE2: begin
                mul_en   = 1'b1;
                mul_src1 = {16'h0, a_q[31:16]};
                mul_src2 = {16'h0, b_q[31:16]};
                cnt_nx   = '0;
                state_nx = (MUL_LATENCY == 1) ? CAPT2 : WAIT2;
            end
            WAIT2: begin
                mul_en   = 1'b1;
                mul_src1 = {16'h0, a_q[31:16]};
                mul_src2 = {16'h0, b_q[31:16]};
                if (cnt == WAIT_LAST) state_nx = CAPT2;
                else cnt_nx = cnt + 2'd1;
            end
            CAPT2: state_nx = RESP;
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Two's-complement fix-up turning the unsigned high word into signed
    always_comb begin
        corr = '0;
        case (op_q)
            2'b10: corr = a_q[31] ? b_q : 32'h0;
            2'b11: corr = (a_q[31] ? b_q : 32'h0)
                        + (b_q[31] ? a_q : 32'h0);
            default: corr = '0;
        endcase
    end

    assign acc_sum = {18'h0, mul_p1}
                   + {2'b0, mul_p2, 16'h0}
                   + {2'b0, mul_p3, 16'h0};

    assign hi = {14'h0, acc_q[49:32]} + mul_p1 - corr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_valid) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state == CAPT1) begin
                acc_q    <= acc_sum;
                result_q <= acc_sum[31:0];
            end
            if (state == CAPT2) result_q <= hi;
        end
    end

    assign resp_valid  = (state == RESP);
    assign resp_result = result_q;

endmodule

// File: tb/tb_telemeter_system_mult_sequencer.sv
// Bench: three sequencers (latency 1, 3, 4), each with a pipelined
// partial-product cell model, checked against a 64-bit reference.
module tb_telemeter_system_mult_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       req_valid, req_ready;
    logic [2:0]       resp_valid, resp_ready, mul_en;
    logic [2:0][1:0]  req_op;
    logic [2:0][31:0] req_a, req_b, resp_result;
    logic [2:0][31:0] mul_src1, mul_src2;
    logic [2:0][31:0] mul_p1, mul_p2, mul_p3;

    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [95:0] pipe [L];
        int en_cnt = 0;

        telemeter_system_mult_sequencer #(.MUL_LATENCY(L)) dut (
            .clk(clk),
            .reset_n(reset_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_op(req_op[g]),
            .req_a(req_a[g]),
            .req_b(req_b[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_result(resp_result[g]),
            .mul_src1(mul_src1[g]),
            .mul_src2(mul_src2[g]),
            .mul_en(mul_en[g]),
            .mul_p1(mul_p1[g]),
            .mul_p2(mul_p2[g]),
            .mul_p3(mul_p3[g])
        );

        always @(posedge clk) begin
            if (mul_en[g]) begin
                en_cnt <= en_cnt + 1;
                pipe[0] <= {
                    {16'h0, mul_src1[g][15:0]} * {16'h0, mul_src2[g][15:0]},
                    {16'h0, mul_src1[g][15:0]} * {16'h0, mul_src2[g][31:16]},
                    {16'h0, mul_src1[g][31:16]} * {16'h0, mul_src2[g][15:0]}};
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign mul_p1[g] = pipe[L-1][95:64];
        assign mul_p2[g] = pipe[L-1][63:32];
        assign mul_p3[g] = pipe[L-1][31:0];
    end

    function automatic int en_get(input int i);
        case (i)
            0: return u[0].en_cnt;
            1: return u[1].en_cnt;
            default: return u[2].en_cnt;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] ref_model(
        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (op[1]) ea = {{32{a[31]}}, a};
        if (op == 2'b11) eb = {{32{b[31]}}, b};
        p = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input int i, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int k;
        k = 0;
        while (!req_ready[i] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 50) chk("req_ready_timeout", 64'(k), 64'(0));
        req_valid[i] = 1'b1;
        req_op[i] = op;
        req_a[i] = a;
        req_b[i] = b;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        k = 0;
        while (!resp_valid[i] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        lat = k;
        res = resp_result[i];
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
    endtask

    typedef struct {
        int          inst;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] r;
        int lat, e0, e2, p0, p2, inst, seen;
        logic [1:0] op;
        logic [31:0] a, b;

        vecs[0] = '{0, 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 2};
        vecs[1] = '{0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4};
        vecs[2] = '{0, 2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4};
        vecs[3] = '{0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4};
        vecs[4] = '{2, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5};
        vecs[5] = '{2, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 10};
        vecs[6] = '{1, 2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 8};
        vecs[7] = '{1, 2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 8};
        vecs[8] = '{1, 2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 4};

        req_valid = '0;
        resp_ready = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 64'(1));
            chk("rst_resp_valid", 64'(resp_valid[i]), 64'(0));
            chk("rst_mul_en", 64'(mul_en[i]), 64'(0));
            chk("rst_result", 64'(resp_result[i]), 64'(0));
            chk("rst_src", 64'({mul_src1[i], mul_src2[i]}), 64'(0));
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            e0 = en_get(vecs[v].inst);
            do_op(vecs[v].inst, vecs[v].op, vecs[v].a, vecs[v].b, r, lat);
            chk($sformatf("vec%0d_result", v), 64'(r), 64'(vecs[v].res));
            chk($sformatf("vec%0d_latency", v), 64'(lat),
                64'(vecs[v].lat));
            chk($sformatf("vec%0d_mul_en", v), 64'(en_get(vecs[v].inst) - e0),
                64'(lat_of(vecs[v].inst) * ((vecs[v].op == 2'b00) ? 1 : 2)));
        end

        // Response back-pressure on the latency-1 unit
        req_valid[0] = 1'b1;
        req_op[0] = 2'b00;
        req_a[0] = 32'h00010003;
        req_b[0] = 32'h00020005;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        seen = 0;
        while (!resp_valid[0] && seen < 20) begin
            @(posedge clk); #1; seen++;
        end
        chk("bp_latency", 64'(seen), 64'(2));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", 64'(resp_valid[0]), 64'(1));
            chk("bp_result", 64'(resp_result[0]), 64'(32'h000B000F));
            chk("bp_req_ready", 64'(req_ready[0]), 64'(0));
            chk("bp_mul_en", 64'(mul_en[0]), 64'(0));
        end
        resp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        chk("bp_retire_req_ready", 64'(req_ready[0]), 64'(0));
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        req_valid[0] = 1'b0;
        chk("bp_after_req_ready", 64'(req_ready[0]), 64'(1));
        chk("bp_after_resp_valid", 64'(resp_valid[0]), 64'(0));

        // Reset pulse in WAIT1 on the latency-3 unit
        req_valid[1] = 1'b1;
        req_op[1] = 2'b00;
        req_a[1] = 32'h00000007;
        req_b[1] = 32'h00000009;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("wait1_mul_en", 64'(mul_en[1]), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready[1]), 64'(1));
        chk("mid_rst_mul_en", 64'(mul_en[1]), 64'(0));
        chk("mid_rst_resp_valid", 64'(resp_valid[1]), 64'(0));
        chk("mid_rst_result", 64'(resp_result[1]), 64'(0));
        chk("mid_rst_src", 64'({mul_src1[1], mul_src2[1]}), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (resp_valid[1]) seen++;
        end
        chk("post_rst_no_resp", 64'(seen), 64'(0));
        do_op(1, 2'b00, 32'h00000003, 32'h00000005, r, lat);
        chk("post_rst_result", 64'(r), 64'(15));
        chk("post_rst_latency", 64'(lat), 64'(4));

        // Random back-to-back traffic at latencies 1 and 4
        e0 = en_get(0);
        e2 = en_get(2);
        p0 = 0;
        p2 = 0;
        for (int n = 0; n < 200; n++) begin
            inst = (n < 100) ? 0 : 2;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (n % 7 == 0) a = {a[31], 31'h0};
            do_op(inst, op, a, b, r, lat);
            chk($sformatf("rand%0d_op%0d", n, op), 64'(r),
                64'(ref_model(op, a, b)));
            chk($sformatf("rand%0d_lat", n), 64'(lat),
                64'((op == 2'b00) ? lat_of(inst) + 1
                                  : 2 * lat_of(inst) + 2));
            if (inst == 0) p0 += (op == 2'b00) ? 1 : 2;
            else p2 += (op == 2'b00) ? 1 : 2;
        end
        chk("rand_mul_en_l1", 64'(en_get(0) - e0), 64'(p0));
        chk("rand_mul_en_l4", 64'(en_get(2) - e2), 64'(4 * p2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
